// File: rtl/pll_clock_monitor_if.sv
// Signal bundle between the PLL supervisor and its surroundings: the raw
// PLL-domain observations and clear request in, the qualified reset and
// frequency measurement out.
interface pll_clock_monitor_if;
  logic        pll_locked;
  logic        pll_tog;
  logic        fault_clr;
  logic        sys_rst;
  logic        good;
  logic [15:0] freq_count;
  logic        count_valid;
  logic        fault;

  // Environment side: drives the PLL observations, watches the verdict.
  modport master (
    output pll_locked, pll_tog, fault_clr,
    input  sys_rst, good, freq_count, count_valid, fault
  );

  // Supervisor side.
  modport slave (
    input  pll_locked, pll_tog, fault_clr,
    output sys_rst, good, freq_count, count_valid, fault
  );
endinterface

// File: rtl/pll_clock_monitor.sv
// PLL supervisor in the reference-clock domain. Synchronises the PLL lock flag
// and a divided PLL toggle, counts toggle edges (both polarities) over fixed
// gate windows, and releases the downstream reset only after a run of
// in-range windows. Lock loss or an out-of-range window after qualification
// re-asserts the reset and raises a sticky fault.
module pll_clock_monitor #(
  parameter int GATE_CYCLES  = 25000,
  parameter int CNT_MIN      = 6700,
  parameter int CNT_MAX      = 6840,
  parameter int GOOD_WINDOWS = 4
) (
  input  logic                clk,
  input  logic                rst,
  pll_clock_monitor_if.slave  mon
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int SW = $clog2(GOOD_WINDOWS + 1);

  localparam logic [GW-1:0] GATE_LAST   = GW'(GATE_CYCLES - 1);
  localparam logic [15:0]   CNT_LO      = 16'(CNT_MIN);
  localparam logic [15:0]   CNT_HI      = 16'(CNT_MAX);
  localparam logic [SW-1:0] STREAK_FULL = SW'(GOOD_WINDOWS);

  typedef enum logic [0:0] {
    WAIT_LOCK = 1'b0,
    MEASURE   = 1'b1
  } state_t;

  state_t        state_r;
  logic          lock_meta_r;
  logic          lock_sync_r;
  logic          tog_meta_r;
  logic          tog_sync_r;
  logic          tog_dly_r;
  logic [GW-1:0] gate_cnt_r;
  logic [15:0]   edge_cnt_r;
  logic [SW-1:0] streak_r;
  logic          sys_rst_r;
  logic          good_r;
  logic [15:0]   freq_count_r;
  logic          count_valid_r;
  logic          fault_r;

  logic          edge_s;
  logic [15:0]   win_count_s;
  logic          pass_s;
  logic [SW-1:0] streak_inc_s;

  // Edge detect, saturating count including this cycle's edge, range check
  // and saturating streak increment.
  always_comb begin
    edge_s       = tog_sync_r ^ tog_dly_r;
    win_count_s  = edge_cnt_r;
    pass_s       = 1'b0;
    streak_inc_s = streak_r;
    if (edge_s && (edge_cnt_r != 16'hFFFF)) begin
      win_count_s = edge_cnt_r + 16'd1;
    end else begin
      win_count_s = edge_cnt_r;
    end
    if ((win_count_s >= CNT_LO) && (win_count_s <= CNT_HI)) begin
      pass_s = 1'b1;
    end else begin
      pass_s = 1'b0;
    end
    if (streak_r == STREAK_FULL) begin
      streak_inc_s = streak_r;
    end else begin
      streak_inc_s = streak_r + SW'(1'b1);
    end
  end

  // Synchronisers, lock/measure state machine and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= WAIT_LOCK;
      lock_meta_r   <= 1'b0;
      lock_sync_r   <= 1'b0;
      tog_meta_r    <= 1'b0;
      tog_sync_r    <= 1'b0;
      tog_dly_r     <= 1'b0;
      gate_cnt_r    <= '0;
      edge_cnt_r    <= 16'd0;
      streak_r      <= '0;
      sys_rst_r     <= 1'b1;
      good_r        <= 1'b0;
      freq_count_r  <= 16'd0;
      count_valid_r <= 1'b0;
      fault_r       <= 1'b0;
    end else begin
      lock_meta_r   <= mon.pll_locked;
      lock_sync_r   <= lock_meta_r;
      tog_meta_r    <= mon.pll_tog;
      tog_sync_r    <= tog_meta_r;
      tog_dly_r     <= tog_sync_r;
      count_valid_r <= 1'b0;
      // A fault event later in this block overrides the clear.
      if (mon.fault_clr) begin
        fault_r <= 1'b0;
      end
      case (state_r)
        WAIT_LOCK: begin
          gate_cnt_r <= '0;
          edge_cnt_r <= 16'd0;
          streak_r   <= '0;
          good_r     <= 1'b0;
          sys_rst_r  <= 1'b1;
          if (lock_sync_r) begin
            state_r <= MEASURE;
          end
        end
        MEASURE: begin
          if (!lock_sync_r) begin
            // Lock lost: drop the partial window without reporting it.
            state_r    <= WAIT_LOCK;
            gate_cnt_r <= '0;
            edge_cnt_r <= 16'd0;
            streak_r   <= '0;
            good_r     <= 1'b0;
            sys_rst_r  <= 1'b1;
            if (good_r) begin
              fault_r <= 1'b1;
            end
          end else if (gate_cnt_r == GATE_LAST) begin
            // Window end: report and judge, next window starts back-to-back.
            gate_cnt_r    <= '0;
            edge_cnt_r    <= 16'd0;
            freq_count_r  <= win_count_s;
            count_valid_r <= 1'b1;
            if (pass_s) begin
              streak_r <= streak_inc_s;
              if (streak_inc_s == STREAK_FULL) begin
                good_r    <= 1'b1;
                sys_rst_r <= 1'b0;
              end
            end else begin
              streak_r  <= '0;
              good_r    <= 1'b0;
              sys_rst_r <= 1'b1;
              if (good_r) begin
                fault_r <= 1'b1;
              end
            end
          end else begin
            gate_cnt_r <= gate_cnt_r + GW'(1'b1);
            edge_cnt_r <= win_count_s;
          end
        end
        default: begin
          state_r    <= WAIT_LOCK;
          gate_cnt_r <= '0;
          edge_cnt_r <= 16'd0;
          streak_r   <= '0;
          good_r     <= 1'b0;
          sys_rst_r  <= 1'b1;
        end
      endcase
    end
  end

  assign mon.sys_rst     = sys_rst_r;
  assign mon.good        = good_r;
  assign mon.freq_count  = freq_count_r;
  assign mon.count_valid = count_valid_r;
  assign mon.fault       = fault_r;

endmodule

// File: tb/tb_pll_clock_monitor.sv
// Bench for pll_clock_monitor with a short gate window. A window-level model
// (delayed observations, a queue of per-cycle edges, a pass streak) predicts
// every output on every cycle; directed phases add hand-computed literals.
module tb_pll_clock_monitor;

  localparam int G  = 100;
  localparam int LO = 25;
  localparam int HI = 29;
  localparam int GW = 4;

  logic clk = 1'b0;
  logic rst;

  pll_clock_monitor_if mon_if();

  pll_clock_monitor #(
    .GATE_CYCLES (G),
    .CNT_MIN     (LO),
    .CNT_MAX     (HI),
    .GOOD_WINDOWS(GW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mon(mon_if)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // toggle generator
  int tog_left = 4;
  int tog_lo   = 4;
  int tog_hi   = 4;

  // model state
  bit m_l1, m_l2, m_t1, m_t2, m_t3;
  bit m_meas;
  int win_q[$];
  int m_streak;
  bit m_fault;
  int m_freq;
  bit m_cv;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  // Advance the model by one clock edge using the inputs the DUT sampled.
  task automatic model_step();
    bit sl, ev, fev;
    int s;
    if (rst) begin
      m_l1 = 0; m_l2 = 0; m_t1 = 0; m_t2 = 0; m_t3 = 0;
      m_meas = 0; win_q.delete(); m_streak = 0;
      m_fault = 0; m_freq = 0; m_cv = 0;
      return;
    end
    sl  = m_l2;           // lock as seen two samples back
    ev  = m_t2 ^ m_t3;    // toggle change seen three samples back
    fev = 0;
    m_cv = 0;
    m_l2 = m_l1; m_l1 = mon_if.pll_locked;
    m_t3 = m_t2; m_t2 = m_t1; m_t1 = mon_if.pll_tog;
    if (!m_meas) begin
      m_streak = 0;
      if (sl) m_meas = 1;
    end else if (!sl) begin
      fev = (m_streak == GW);
      m_streak = 0;
      m_meas = 0;
      win_q.delete();
    end else begin
      win_q.push_back(int'(ev));
      if (win_q.size() == G) begin
        s = 0;
        foreach (win_q[i]) s += win_q[i];
        if (s > 65535) s = 65535;
        win_q.delete();
        m_freq = s;
        m_cv = 1;
        if (s >= LO && s <= HI) begin
          if (m_streak < GW) m_streak++;
        end else begin
          fev = (m_streak == GW);
          m_streak = 0;
        end
      end
    end
    if (fev) m_fault = 1;
    else if (mon_if.fault_clr) m_fault = 0;
  endtask

  // One clock: wait for the sampling edge, update model, compare all outputs.
  task automatic cycle();
    int g;
    @(negedge clk);
    cyc++;
    model_step();
    g = (m_streak == GW) ? 1 : 0;
    check("sys_rst",     int'(mon_if.sys_rst),     1 - g);
    check("good",        int'(mon_if.good),        g);
    check("freq_count",  int'(mon_if.freq_count),  m_freq);
    check("count_valid", int'(mon_if.count_valid), int'(m_cv));
    check("fault",       int'(mon_if.fault),       int'(m_fault));
  endtask

  task automatic step();
    tog_left--;
    if (tog_left <= 0) begin
      mon_if.pll_tog = ~mon_if.pll_tog;
      tog_left = int'($urandom_range(tog_hi, tog_lo));
    end
    cycle();
  endtask

  // Run from rst release until the first count_valid; return its cycle index.
  task automatic first_cv_latency(output int k_first);
    k_first = 0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (mon_if.count_valid && k_first == 0) k_first = k;
    end
  endtask

  initial begin
    int ncv, k_first, done, clr_now, lat;
    rst = 1'b1;
    mon_if.pll_locked = 1'b1;
    mon_if.pll_tog    = 1'b0;
    mon_if.fault_clr  = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check("reset_sys_rst", int'(mon_if.sys_rst), 1);
    check("reset_good",    int'(mon_if.good), 0);
    check("reset_freq",    int'(mon_if.freq_count), 0);
    check("reset_fault",   int'(mon_if.fault), 0);

    // Qualification with an edge every 4 cycles: exactly 25 per window.
    rst = 1'b0;
    ncv = 0;
    for (int k = 1; k <= 420; k++) begin
      step();
      if (mon_if.count_valid) begin
        ncv++;
        if (ncv == 1) check("first_cv_cycle", k, 103);
        if (ncv == 4) check("qualify_cycle", k, 403);
        check("q_freq", int'(mon_if.freq_count), 25);
        check("q_good", int'(mon_if.good), (ncv >= 4) ? 1 : 0);
      end
    end
    check("q_cv_count", ncv, 4);
    check("q_fault", int'(mon_if.fault), 0);

    // Lock drop mid-window while qualified.
    for (int k = 0; k < 37; k++) step();
    mon_if.pll_locked = 1'b0;
    step(); step();
    check("drop_2cyc_sys_rst", int'(mon_if.sys_rst), 0);
    step();
    check("drop_3cyc_sys_rst", int'(mon_if.sys_rst), 1);
    check("drop_3cyc_good",    int'(mon_if.good), 0);
    check("drop_fault",        int'(mon_if.fault), 1);
    for (int k = 0; k < 50; k++) step();
    mon_if.pll_locked = 1'b1;
    for (int k = 0; k < 450; k++) step();
    check("relock_good",  int'(mon_if.good), 1);
    check("relock_fault", int'(mon_if.fault), 1);

    // Slow toggle: window fails, then steady 20 edges per window.
    tog_lo = 5; tog_hi = 5;
    for (int k = 0; k < 250; k++) step();
    check("slow_good",  int'(mon_if.good), 0);
    check("slow_fault", int'(mon_if.fault), 1);
    for (int k = 0; k < 300; k++) begin
      step();
      if (mon_if.count_valid) check("slow_freq20", int'(mon_if.freq_count), 20);
    end
    check("slow_sys_rst", int'(mon_if.sys_rst), 1);
    tog_lo = 4; tog_hi = 4;
    for (int k = 0; k < 450; k++) step();
    check("requal_good",  int'(mon_if.good), 1);
    check("requal_fault", int'(mon_if.fault), 1);

    // fault_clr coincident with a failing window: set wins.
    tog_lo = 5; tog_hi = 5;
    done = 0;
    for (int k = 0; k < 400 && done == 0; k++) begin
      clr_now = (m_meas && win_q.size() == G - 1) ? 1 : 0;
      mon_if.fault_clr = clr_now[0];
      step();
      mon_if.fault_clr = 1'b0;
      if (clr_now != 0 && m_cv && (m_freq < LO || m_freq > HI)) begin
        check("clr_vs_event_fault", int'(mon_if.fault), 1);
        check("clr_vs_event_good",  int'(mon_if.good), 0);
        done = 1;
      end
    end
    if (done == 0) check("clr_vs_event_found", 0, 1);
    done = 0;
    for (int k = 0; k < 200 && done == 0; k++) begin
      step();
      if (win_q.size() == 10) done = 1;
    end
    mon_if.fault_clr = 1'b1;
    step();
    mon_if.fault_clr = 1'b0;
    check("clr_alone_fault", int'(mon_if.fault), 0);

    // rst pulsed at gate count 50.
    tog_lo = 4; tog_hi = 4;
    done = 0;
    for (int k = 0; k < 300 && done == 0; k++) begin
      step();
      if (m_meas && win_q.size() == 50) done = 1;
    end
    if (done == 0) check("rst_mid_found", 0, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_sys_rst", int'(mon_if.sys_rst), 1);
    check("rst_mid_good",    int'(mon_if.good), 0);
    check("rst_mid_freq",    int'(mon_if.freq_count), 0);
    check("rst_mid_cv",      int'(mon_if.count_valid), 0);
    check("rst_mid_fault",   int'(mon_if.fault), 0);
    first_cv_latency(lat);
    check("rst_mid_first_cv", lat, 103);

    // Randomised traffic: mixed edge rates, lock drops, clears, resets.
    for (int k = 0; k < 15000; k++) begin
      if (k % 700 == 0) begin
        case ($urandom_range(3, 0))
          0:       begin tog_lo = 3; tog_hi = 4; end
          1:       begin tog_lo = 3; tog_hi = 5; end
          2:       begin tog_lo = 4; tog_hi = 4; end
          default: begin tog_lo = 5; tog_hi = 5; end
        endcase
      end
      if (mon_if.pll_locked) begin
        if ($urandom_range(499, 0) == 0) mon_if.pll_locked = 1'b0;
      end else begin
        if ($urandom_range(29, 0) == 0) mon_if.pll_locked = 1'b1;
      end
      mon_if.fault_clr = ($urandom_range(149, 0) == 0);
      rst = ($urandom_range(2999, 0) == 0);
      step();
    end
    rst = 1'b0;
    mon_if.fault_clr = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
